send_wr_data: RTL
=================

// Module: send_wr_data
// PURPOSE
//  AXI4 write-data/response stage of the DMA write path; runs beside the AW command issuer.
//  On start it streams size+1 beats from an upstream data stream (read side of the DMA FIFO) onto W.
//  Beats are split into 256-beat bursts; the final burst carries size[7:0]+1 beats; WLAST ends each burst.
//  Collects one B response per burst, then raises done; a non-OKAY response raises a sticky error.
// PARAMETERS
//  C_AXI_DATA_WIDTH  32  W/stream data width in bits (multiple of 8)
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      asynchronous active-low reset
//  start          in   1      1-cycle pulse, begin transfer (ignored unless IDLE)
//  size           in   16     total beats - 1 (same encoding as the AW issuer)
//  s_data         in   DW     upstream data beat
//  s_valid        in   1      upstream beat valid
//  s_ready        out  1      upstream beat accepted when s_valid & s_ready
//  M_AXI_WDATA    out  DW     write data (= s_data)
//  M_AXI_WSTRB    out  DW/8   byte strobes, all ones
//  M_AXI_WLAST    out  1      last beat of current burst
//  M_AXI_WVALID   out  1      write data valid
//  M_AXI_WREADY   in   1      slave accepts W beat
//  M_AXI_BRESP    in   2      write response
//  M_AXI_BVALID   in   1      response valid
//  M_AXI_BREADY   out  1      response accept
//  busy           out  1      high from start accepted until done
//  done           out  1      1-cycle pulse, all data sent and all B received
//  err            out  1      sticky: any BRESP != 2'b00 this transfer
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0; s_ready, WVALID, WLAST, BREADY, busy, done, err = 0.
//  States: IDLE -> DATA on start (latch size, clear err, counters) -> WAIT_B after last W beat -> IDLE.
//  DATA: WVALID = s_valid; s_ready = WREADY; beat moves on s_valid & WREADY (zero latency, no buffering).
//  Outside DATA: WVALID = s_ready = 0; upstream data untouched.
//  beat_in_burst (8b) increments per W beat, clears after WLAST beat.
//  burst_idx (8b) increments after each WLAST beat; last_burst = (burst_idx == size_q[15:8]).
//  WLAST = (beat_in_burst == (last_burst ? size_q[7:0] : 8'hFF)); combinational, valid with WVALID.
//  WLAST beat of last burst accepted -> WAIT_B next cycle.
//  BREADY = 1 in DATA and WAIT_B (responses may precede later data); 0 in IDLE.
//  b_cnt (9b) increments on BVALID & BREADY; expected = size_q[15:8] + 1 (9-bit, max 256).
//  BRESP != 0 on any accepted response sets err; err held until next accepted start.
//  WAIT_B: when b_cnt == expected (incl. count reached in same cycle) -> done=1 for 1 cycle, IDLE.
//  busy = (state != IDLE); done asserts in cycle state returns to IDLE.
//  Extra B in IDLE is not accepted (BREADY=0).
//  start while busy: ignored, no latch change.
//  rst_n low mid-transfer: immediate return to reset values; partial burst abandoned.
//  WVALID/WDATA stability under backpressure relies on upstream holding s_data while s_valid & !s_ready.
// TESTING
//  size=0, WREADY=1, stream valid -> 1 beat, WLAST=1 on it; 1 B OKAY -> done 1 cycle, err=0.
//  size=16'h01FF -> 2 bursts of 256; WLAST on beats 255 and 511 only; done after 2nd B.
//  size=16'h0104, random WREADY/s_valid gaps -> 256+5 beats, data order preserved, no beat lost/duplicated.
//  size=16'h00FF, BRESP=2'b10 on the only B -> done pulses, err=1; next start clears err.
//  B for burst 0 returned while burst 1 data still streaming -> counted; done only after 2nd B.
//  rst_n asserted mid-burst -> all outputs 0 next edge; new start runs a clean transfer.

Source files
------------

// File: rtl/send_wr_data.sv
// send_wr_data: streams size+1 beats onto AXI4 W in 256-beat bursts and collects one B per burst
module send_wr_data #(
   parameter int C_AXI_DATA_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [15:0]                     size,
   input  logic [C_AXI_DATA_WIDTH-1:0]     s_data,
   input  logic                            s_valid,
   output logic                            s_ready,
   output logic [C_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                            M_AXI_WLAST,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic                            busy,
   output logic                            done,
   output logic                            err
);
   typedef enum logic [1:0] {IDLE, DATA, WAIT_B} state_t;
   state_t      state_q, state_d;
   logic [15:0] size_q, size_d;
   logic [7:0]  beat_q, beat_d, burst_q, burst_d;
   logic [8:0]  b_cnt_q, b_cnt_d, b_exp;
   logic        err_q, err_d, done_q, done_d;
   logic        in_data, last_burst, w_fire, b_fire;
   assign in_data      = state_q == DATA;
   assign last_burst   = burst_q == size_q[15:8];
   assign b_exp        = {1'b0, size_q[15:8]} + 9'd1;
   assign M_AXI_WDATA  = s_data;
   assign M_AXI_WSTRB  = '1;
   assign M_AXI_WVALID = in_data && s_valid;
   assign s_ready      = in_data && M_AXI_WREADY;
   assign M_AXI_WLAST  = in_data && (beat_q == (last_burst ? size_q[7:0] : 8'hFF));
   assign M_AXI_BREADY = state_q != IDLE;
   assign busy         = state_q != IDLE;
   assign done         = done_q;
   assign err          = err_q;
   assign w_fire       = M_AXI_WVALID && M_AXI_WREADY;
   assign b_fire       = M_AXI_BVALID && M_AXI_BREADY;
   // next state: beat/burst counting on W, response counting on B, done when every B is in
   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      beat_d  = beat_q;
      burst_d = burst_q;
      b_cnt_d = b_cnt_q + {8'd0, b_fire};
      err_d   = err_q | (b_fire && M_AXI_BRESP != 2'b00);
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = DATA;
            size_d  = size;
            beat_d  = '0;
            burst_d = '0;
            b_cnt_d = '0;
            err_d   = 1'b0;
         end
         DATA: if (w_fire) begin
            beat_d  = M_AXI_WLAST ? 8'd0 : beat_q + 8'd1;
            burst_d = M_AXI_WLAST ? burst_q + 8'd1 : burst_q;
            state_d = (M_AXI_WLAST && last_burst) ? WAIT_B : DATA;
         end
         WAIT_B: if (b_cnt_d == b_exp) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and counter registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         size_q  <= '0;
         beat_q  <= '0;
         burst_q <= '0;
         b_cnt_q <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         size_q  <= size_d;
         beat_q  <= beat_d;
         burst_q <= burst_d;
         b_cnt_q <= b_cnt_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end
endmodule
